// File: rtl/dogbattle_pkg.sv
// Shared timing constants, derived VGA timing values and coordinate types for
// the Dog Battle frame sequencer.
package dogbattle_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned FRAME_W = 8;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic {
    UPD_IDLE = 1'b0,
    UPD_REQ  = 1'b1
  } upd_state_e;

  localparam int unsigned DEF_CLK_DIV  = 2;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned HS_END   = HS_START + DEF_H_SYNC;
  localparam int unsigned VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned VS_END   = VS_START + DEF_V_SYNC;

endpackage

// File: rtl/dogbattle_axis_counter.sv
// Enable-gated wrap counter (0..MAX) with a terminal-count flag; used for both
// the horizontal and vertical raster axes.
module dogbattle_axis_counter
  import dogbattle_pkg::*;
#(
  parameter int unsigned MAX = H_TOTAL - 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_en,
  output coord_t o_cnt,
  output logic   o_tc_c
);

  coord_t r_cnt;

  assign o_tc_c = (r_cnt == COORD_W'(MAX));
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc_c ? '0 : r_cnt + COORD_W'(1);
    end
  end

endmodule

// File: rtl/dogbattle_frame_sched.sv
// VGA frame sequencer: pixel strobe, raster counters, sync/blank decode and the
// per-frame game-update handshake. Define DOGBATTLE_UPD_WDOG_EN to build the
// sticky overrun detector.
module dogbattle_frame_sched
  import dogbattle_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_en,
  output coord_t             x,
  output coord_t             y,
  output logic               active,
  output logic               hsync,
  output logic               vsync,
  output logic               upd_req,
  input  logic               upd_ack,
  output logic               overrun,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned DIV_W       = $clog2(CLK_DIV);
  localparam int unsigned LP_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned LP_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned LP_HS_START = H_ACTIVE + H_FP;
  localparam int unsigned LP_HS_END   = LP_HS_START + H_SYNC;
  localparam int unsigned LP_VS_START = V_ACTIVE + V_FP;
  localparam int unsigned LP_VS_END   = LP_VS_START + V_SYNC;

  logic [DIV_W-1:0]   r_div;
  logic               w_pix_en;
  logic               w_x_tc;
  logic               w_y_tc;
  logic               w_vblank_start;
  logic               w_frame_wrap;
  upd_state_e         r_upd_state;
  upd_state_e         w_upd_next;
  logic [FRAME_W-1:0] r_frame_cnt;

  // Pixel strobe divider
  assign w_pix_en = (r_div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_pix_en) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  dogbattle_axis_counter #(.MAX(LP_H_TOTAL - 1)) u_x_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_pix_en),
    .o_cnt  (x),
    .o_tc_c (w_x_tc)
  );

  dogbattle_axis_counter #(.MAX(LP_V_TOTAL - 1)) u_y_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_pix_en & w_x_tc),
    .o_cnt  (y),
    .o_tc_c (w_y_tc)
  );

  // Raster events, qualified on the strobe that moves the counters
  assign w_vblank_start = w_pix_en & w_x_tc & (y == COORD_W'(V_ACTIVE - 1));
  assign w_frame_wrap   = w_pix_en & w_x_tc & w_y_tc;

  assign pix_en = w_pix_en;
  assign active = (x < COORD_W'(H_ACTIVE)) && (y < COORD_W'(V_ACTIVE));
  assign hsync  = !((x >= COORD_W'(LP_HS_START)) && (x < COORD_W'(LP_HS_END)));
  assign vsync  = !((y >= COORD_W'(LP_VS_START)) && (y < COORD_W'(LP_VS_END)));

  // Update handshake; a new request takes priority over a concurrent ack
  always_ff @(posedge clk) begin
    if (rst) begin
      r_upd_state <= UPD_IDLE;
    end else begin
      r_upd_state <= w_upd_next;
    end
  end

  always_comb begin
    w_upd_next = r_upd_state;
    case (r_upd_state)
      UPD_IDLE: if (w_vblank_start) w_upd_next = UPD_REQ;
      UPD_REQ:  if (!w_vblank_start && upd_ack) w_upd_next = UPD_IDLE;
      default:  w_upd_next = UPD_IDLE;
    endcase
  end

  assign upd_req = (r_upd_state == UPD_REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_frame_wrap) begin
      r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
    end
  end

  assign frame_cnt = r_frame_cnt;

`ifdef DOGBATTLE_UPD_WDOG_EN
  logic r_overrun;

  // Sticky: a request still pending when the frame wraps missed its window
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_frame_wrap && upd_req) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_dogbattle_frame_sched.sv
// Directed bench for dogbattle_frame_sched with default horizontal timing and a
// shortened vertical raster (8 lines) to keep whole frames short.
module tb_dogbattle_frame_sched;

  logic       clk;
  logic       rst;
  logic       pix_en;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic       hsync;
  logic       vsync;
  logic       upd_req;
  logic       upd_ack;
  logic       overrun;
  logic [7:0] frame_cnt;

  int n_checks;
  int n_errors;
  int cyc;

`ifdef DOGBATTLE_UPD_WDOG_EN
  localparam logic [31:0] EXP_OVR = 32'd1;
`else
  localparam logic [31:0] EXP_OVR = 32'd0;
`endif

  dogbattle_frame_sched #(
    .CLK_DIV  (2),
    .H_ACTIVE (640),
    .H_FP     (16),
    .H_SYNC   (96),
    .H_BP     (48),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_en    (pix_en),
    .x         (x),
    .y         (y),
    .active    (active),
    .hsync     (hsync),
    .vsync     (vsync),
    .upd_req   (upd_req),
    .upd_ack   (upd_ack),
    .overrun   (overrun),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_x"},       32'(x),         32'd0);
    check({pfx, "_y"},       32'(y),         32'd0);
    check({pfx, "_pix_en"},  32'(pix_en),    32'd0);
    check({pfx, "_active"},  32'(active),    32'd1);
    check({pfx, "_hsync"},   32'(hsync),     32'd1);
    check({pfx, "_vsync"},   32'(vsync),     32'd1);
    check({pfx, "_upd_req"}, 32'(upd_req),   32'd0);
    check({pfx, "_overrun"}, 32'(overrun),   32'd0);
    check({pfx, "_fcnt"},    32'(frame_cnt), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst      = 1'b1;
    upd_ack  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("rst");

    // Strobe on odd cycles after the reset edge
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("pix_en_c%0d", i), 32'(pix_en), 32'(i % 2));
    end

    // Horizontal line: x = cyc/2 in the first line
    run_to(1279); check("active_x639", 32'(active), 32'd1);
    run_to(1280); check("active_x640", 32'(active), 32'd0);
    check("x_640", 32'(x), 32'd640);
    run_to(1311); check("hsync_x655", 32'(hsync), 32'd1);
    run_to(1312); check("hsync_x656", 32'(hsync), 32'd0);
    run_to(1503); check("hsync_x751", 32'(hsync), 32'd0);
    run_to(1504); check("hsync_x752", 32'(hsync), 32'd1);
    run_to(1599); check("x_799", 32'(x), 32'd799); check("y_line0", 32'(y), 32'd0);
    run_to(1600); check("x_wrap", 32'(x), 32'd0); check("y_line1", 32'(y), 32'd1);

    run_to(4800); check("active_y3", 32'(active), 32'd1);

    // Vblank start at y=4 raises the request; ack 100 clk later clears it
    run_to(6399); check("req_pre_vblank", 32'(upd_req), 32'd0);
    run_to(6400); check("req_vblank", 32'(upd_req), 32'd1);
    check("y_vblank", 32'(y), 32'd4); check("active_y4", 32'(active), 32'd0);
    run_to(6410); check("vsync_y4", 32'(vsync), 32'd1);
    run_to(6500); upd_ack = 1'b1; check("req_ack_applied", 32'(upd_req), 32'd1);
    run_to(6501); check("req_after_ack", 32'(upd_req), 32'd0);
    check("ovr_after_ack", 32'(overrun), 32'd0);
    upd_ack = 1'b0;

    // Ack while idle does nothing
    run_to(6800); upd_ack = 1'b1;
    run_to(6801); upd_ack = 1'b0; check("req_idle_ack1", 32'(upd_req), 32'd0);
    run_to(6802); check("req_idle_ack2", 32'(upd_req), 32'd0);

    run_to(8010);  check("vsync_y5", 32'(vsync), 32'd0);
    run_to(9610);  check("vsync_y6", 32'(vsync), 32'd0);
    run_to(11210); check("vsync_y7", 32'(vsync), 32'd1);

    // Frame wrap after 800*8*2 clk
    run_to(12799); check("fcnt_pre_wrap", 32'(frame_cnt), 32'd0);
    check("y_last", 32'(y), 32'd7);
    run_to(12800); check("fcnt_wrap1", 32'(frame_cnt), 32'd1);
    check("x_frame", 32'(x), 32'd0); check("y_frame", 32'(y), 32'd0);
    check("ovr_wrap1", 32'(overrun), 32'd0);

    // Second frame: request left unanswered
    run_to(19199); check("req_pre_vblank2", 32'(upd_req), 32'd0);
    run_to(19200); check("req_vblank2", 32'(upd_req), 32'd1);
    run_to(25599); check("ovr_pre_wrap2", 32'(overrun), 32'd0);
    run_to(25600); check("ovr_wrap2", 32'(overrun), EXP_OVR);
    check("req_held_wrap2", 32'(upd_req), 32'd1);
    check("fcnt_wrap2", 32'(frame_cnt), 32'd2);

    // Mid-frame reset at (300, 3) with a pending request
    run_to(31000);
    check("x_mid", 32'(x), 32'd300); check("y_mid", 32'(y), 32'd3);
    check("req_mid", 32'(upd_req), 32'd1); check("ovr_mid", 32'(overrun), EXP_OVR);
    rst = 1'b1;
    run_to(31001);
    check_reset_state("midrst");
    rst = 1'b0;
    run_to(31002); check("pix_en_after_midrst", 32'(pix_en), 32'd1);

    // Frame counter wrap 255 -> 0 from a forced preload
    force dut.r_frame_cnt = 8'd255;
    #1;
    release dut.r_frame_cnt;
    check("fcnt_preload", 32'(frame_cnt), 32'd255);
    run_to(43800); check("fcnt_pre_wrap255", 32'(frame_cnt), 32'd255);
    run_to(43801); check("fcnt_wrap0", 32'(frame_cnt), 32'd0);
    check("x_wrap255", 32'(x), 32'd0); check("y_wrap255", 32'(y), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
